restoring_divider: RTL

RESTORING_DIVIDER -- requirements
Module: restoring_divider

---
 rtl/restoring_divider_if.sv | 28 ++
 rtl/restoring_divider.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/restoring_divider_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | restoring_divider_if : request/result bundle for restoring_divider    |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
interface restoring_divider_if #(
  parameter int WIDTH = 8
) ();
  logic             start;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             div_by_zero;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, div_by_zero
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, div_by_zero
  );
endinterface
`default_nettype wire

// File: rtl/restoring_divider.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | restoring_divider : unsigned WIDTH-bit restoring divider, one bit/clk |
// | Revision 1.0                                                          |
// +----------------------------------------------------------------------+
module restoring_divider #(
  parameter int WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  restoring_divider_if.slave  bus
);

  localparam int                 c_CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(WIDTH - 1);

  localparam logic [1:0] c_IDLE = 2'd0;
  localparam logic [1:0] c_RUN  = 2'd1;
  localparam logic [1:0] c_DONE = 2'd2;

  logic [1:0]         r_state;
  logic [1:0]         w_next;
  logic [WIDTH-1:0]   r_dvd;
  logic [WIDTH-1:0]   r_dvs;
  logic [WIDTH:0]     r_pr;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_quot;
  logic [WIDTH-1:0]   r_rem;
  logic               r_dbz;

  logic               w_busy;
  logic               w_done;
  logic               w_accept;
  logic               w_div0;
  logic               w_last;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH:0]     w_b;
  logic [WIDTH:0]     w_diff;
  logic [WIDTH:0]     w_new_pr;
  logic [WIDTH+1:0]   w_carry;
  logic               w_no_borrow;
  logic               w_unused_pr_msb;

  assign w_accept        = bus.start && (r_state != c_RUN);
  assign w_div0          = (bus.divisor == '0);
  assign w_last          = (r_cnt == c_LAST);
  // The remainder is always below the divisor, so the top bit never survives a shift.
  assign w_unused_pr_msb = r_pr[WIDTH];

  assign w_shift    = {r_pr[WIDTH-1:0], r_dvd[WIDTH-1]};
  assign w_b        = {1'b0, r_dvs};
  assign w_carry[0] = 1'b1;

  generate
    for (genvar i = 0; i <= WIDTH; i++) begin : g_fa
      logic w_bn;
      assign w_bn           = ~w_b[i];
      assign w_diff[i]      = w_shift[i] ^ w_bn ^ w_carry[i];
      assign w_carry[i + 1] = (w_shift[i] & w_bn) | (w_carry[i] & (w_shift[i] ^ w_bn));
    end
  endgenerate

  // Carry-out of a + ~b + 1 is the inverted borrow: set means the trial is non-negative.
  assign w_no_borrow = w_carry[WIDTH+1];
  assign w_new_pr    = w_no_borrow ? w_diff : w_shift;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= c_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      c_IDLE, c_DONE: begin
        if (bus.start) begin
          w_next = w_div0 ? c_DONE : c_RUN;
        end else begin
          w_next = c_IDLE;
        end
      end
      c_RUN: begin
        if (w_last) begin
          w_next = c_DONE;
        end
      end
      default: w_next = c_IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      c_RUN:   w_busy = 1'b1;
      c_DONE:  w_done = 1'b1;
      default: ;
    endcase
  end

  // Dividend bits shift out of r_dvd MSB-first while quotient bits fill in at the LSB.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dvd  <= '0;
      r_dvs  <= '0;
      r_pr   <= '0;
      r_cnt  <= '0;
      r_quot <= '0;
      r_rem  <= '0;
      r_dbz  <= 1'b0;
    end else if (w_accept) begin
      r_dvd <= bus.dividend;
      r_dvs <= bus.divisor;
      r_pr  <= '0;
      r_cnt <= '0;
      if (w_div0) begin
        r_quot <= '1;
        r_rem  <= bus.dividend;
        r_dbz  <= 1'b1;
      end else begin
        r_dbz  <= 1'b0;
      end
    end else if (r_state == c_RUN) begin
      r_pr  <= w_new_pr;
      r_dvd <= {r_dvd[WIDTH-2:0], w_no_borrow};
      r_cnt <= r_cnt + 1'b1;
      if (w_last) begin
        r_quot <= {r_dvd[WIDTH-2:0], w_no_borrow};
        r_rem  <= w_new_pr[WIDTH-1:0];
      end
    end
  end

  assign bus.busy        = w_busy;
  assign bus.done        = w_done;
  assign bus.quotient    = r_quot;
  assign bus.remainder   = r_rem;
  assign bus.div_by_zero = r_dbz;

endmodule
`default_nettype wire
